// File: rtl/gdma_pkt_pkg.sv
// Shared types and word-format constants for the gdma packet link arbiter.
package gdma_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHIP_POS = 2'd1,
    WORD_LEN = 2'd2,
    DATA     = 2'd3
  } pkt_state_e;

  localparam int LEN_MSB = 30;
  localparam int WORD_W  = 32;

endpackage

// File: rtl/gdma_rr_arbiter.sv
// Rotate-priority request picker: first requester scanning upward from last_grant+1.
module gdma_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last_grant,
  output logic               any_req,
  output logic [SRC_W-1:0]   next_grant
);

  localparam int unsigned N = NUM_SRC;

  int unsigned idx;

  always_comb begin
    any_req    = 1'b0;
    next_grant = last_grant;
    idx        = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = 32'(last_grant) + k;
      if (idx >= N) idx = idx - N;
      if (!any_req && req[idx[SRC_W-1:0]]) begin
        any_req    = 1'b1;
        next_grant = idx[SRC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/gdma_pkt_arbiter.sv
// Packet-granular round-robin sharing of the 32-bit gdma-to-GTP stream link.
module gdma_pkt_arbiter
  import gdma_pkt_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_start,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  output logic [NUM_SRC-1:0]        s_tready,
  input  logic [NUM_SRC*WORD_W-1:0] s_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [WORD_W-1:0]         m_tdata,
  output logic [SRC_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      pkt_done
);

  pkt_state_e        state_q, state_d;
  logic [LEN_MSB:0]  cnt_q, cnt_d;
  logic [SRC_W-1:0]  grant_q, grant_d;
  logic [SRC_W-1:0]  last_q, last_d;
  logic              done_d;
  logic              any_req;
  logic [SRC_W-1:0]  next_grant;
  logic              owned;
  logic              xfer;
  logic [WORD_W-1:0] src_data [NUM_SRC];

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_data[i] = s_tdata[WORD_W*i +: WORD_W];
    end
  end

  gdma_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr (
    .req        (s_tvalid),
    .last_grant (last_q),
    .any_req    (any_req),
    .next_grant (next_grant)
  );

  // op_start gates the pass-through in its own cycle so nothing leaks from a truncated packet
  always_comb begin
    owned    = (state_q != IDLE) && !op_start;
    m_tvalid = owned && s_tvalid[grant_q];
    m_tdata  = src_data[grant_q];
    s_tready = '0;
    if (owned) s_tready[grant_q] = m_tready;
    xfer     = m_tvalid && m_tready;
    busy     = (state_q != IDLE);
    grant_id = grant_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    done_d  = 1'b0;
    if (op_start) begin
      state_d = IDLE;
      cnt_d   = '0;
      last_d  = SRC_W'(NUM_SRC - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_d = next_grant;
            last_d  = next_grant;
            state_d = CHIP_POS;
          end
        end
        CHIP_POS: if (xfer) state_d = WORD_LEN;
        WORD_LEN: begin
          if (xfer) begin
            cnt_d   = m_tdata[LEN_MSB:0];
            state_d = DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            if (cnt_q == '0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      grant_q  <= '0;
      last_q   <= SRC_W'(NUM_SRC - 1);
      pkt_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      pkt_done <= done_d;
    end
  end

endmodule

// File: doc/gdma_pkt_arbiter.md
Name: gdma_pkt_arbiter

Overview:
- Shares the single 32-bit gdma-to-GTP stream link among NUM_SRC gdma read channels.
- Arbitration is packet-granular round-robin. Once a source is granted, it owns the link for one whole packet.
- Packet format: word0 = chip position, word1 = word length L (bits[30:0]), then L+1 data words.
- The block sits between the per-channel gdma read streams and the downstream packager/speed-divider stage.

Parameters:
NUM_SRC, 4, number of requesting stream sources (2..16)
SRC_W, $clog2(NUM_SRC), width of the source index

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
op_start  input  1  synchronous abort/restart pulse
s_tvalid  input  NUM_SRC  per-source valid
s_tready  output  NUM_SRC  per-source ready
s_tdata  input  NUM_SRC*32  per-source data; source i occupies bits [32*i+31:32*i]
m_tvalid  output  1  link valid
m_tready  input  1  link ready
m_tdata  output  32  link data
grant_id  output  SRC_W  index of the source currently or last granted
busy  output  1  high while a packet is owned (any state other than IDLE)
pkt_done  output  1  one-cycle pulse, registered, in the cycle after the last data word transfers

Behaviour:
- Reset values:
  - state = IDLE; m_tvalid = 0; s_tready = 0; busy = 0; pkt_done = 0.
  - grant_id = 0; last-grant pointer = NUM_SRC-1, so source 0 has first priority.
  - cnt = 0.
- States: IDLE, CHIP_POS, WORD_LEN, DATA.
- IDLE:
  - m_tvalid = 0; all s_tready = 0.
  - If any s_tvalid is high, pick the first requesting index scanning upward (with wrap) from last_grant+1.
  - Register grant_id and last_grant, then go to CHIP_POS. Grant latency is 1 cycle.
  - No request: stay in IDLE.
- Non-IDLE datapath (combinational pass-through, no added latency):
  - m_tvalid = s_tvalid[grant_id]; m_tdata = s_tdata[grant_id].
  - s_tready[grant_id] = m_tready; all other s_tready = 0.
  - A transfer is m_tvalid && m_tready.
- CHIP_POS: on a transfer, go to WORD_LEN. The word is forwarded unchanged.
- WORD_LEN: on a transfer, load cnt = tdata[30:0] and go to DATA. Bit 31 is forwarded unchanged and ignored for counting.
- DATA:
  - On a transfer with cnt == 0: go to IDLE and assert pkt_done next cycle.
  - On a transfer with cnt != 0: decrement cnt.
  - Exactly L+1 data words are passed.
- No transfer: state, cnt and grant hold. Backpressure has unlimited duration. s_tvalid dropping mid-packet simply stalls.
- One idle bubble cycle between consecutive packets is mandatory. It is the re-arbitration cycle, even when the same source wins.
- Non-granted sources are never acknowledged. Their s_tvalid/s_tdata must remain stable (AXI-stream rule).
- cnt is 31 bits. L = 0x7FFFFFFF is legal, with no wrap. Decrement never goes below 0.
- op_start (synchronous, has priority over all transitions):
  - state -> IDLE; cnt -> 0; last_grant -> NUM_SRC-1; pkt_done -> 0.
  - An in-flight packet is truncated, with no further words forwarded.
  - The pulse cycle itself drives m_tvalid = 0 and s_tready = 0.
- Async rst mid-packet: same effect as op_start, applied immediately.
- A request present in the same cycle as op_start is not granted until the following IDLE cycle.

Decomposition:
- Package gdma_pkt_pkg:
  - State encodings: IDLE = 2'd0, CHIP_POS = 2'd1, WORD_LEN = 2'd2, DATA = 2'd3.
  - Word-format constants: LEN_MSB = 30, WORD_W = 32.
- Sub-module gdma_rr_arbiter (parameter NUM_SRC):
  - Inputs: req vector, last_grant.
  - Outputs: any_req, next_grant (combinational rotate-priority pick).
  - Reused by future link-sharing blocks.

Test Plan:
- Single source 0, L = 2, m_tready = 1 → grant after 1 IDLE cycle; 5 words forwarded in 5 consecutive cycles; pkt_done pulses the cycle after word 5; busy drops with it.
- All 4 sources request continuously with L = 0 → grant order 0,1,2,3,0; each packet is 3 words; 1 bubble cycle between packets; no s_tready to a non-granted source.
- Source 2, L = 3, m_tready toggling 1-0 each cycle → all 6 words delivered in order with no duplication; cnt holds during ready-low cycles.
- Length word 0x8000_0001 → forwarded verbatim; exactly 2 data words follow; bit 31 does not affect the count.
- op_start asserted on the 2nd data word of an L = 5 packet → m_tvalid = 0 from that cycle; state IDLE; next grant goes to source 0 even if source 1 was previously next.
- rst asserted mid-DATA → all outputs at reset values immediately; after release, a fresh packet from source 3 passes intact.
